gelato_banked_register_file: RTL and testbench

- Multi-bank, multi-port successor of the single-port warp register bank; sits between the issue stage and the operand collectors.
- Serves READ_PORTS independent read channels plus one masked write channel per cycle across BANK_NUM banks.
- Arbitrates same-bank conflicts round-robin and returns tagged read data one cycle after grant.

---
 rtl/gelato_banked_register_file_pkg.sv | 28 ++
 rtl/gelato_rr_arbiter.sv | 51 +++++
 rtl/gelato_banked_register_file.sv | 183 ++++++++++++++++++
 tb/tb_gelato_banked_register_file.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gelato_banked_register_file_pkg.sv
// Shared types and defaults for the banked warp register file.
// Contents:
//   - default geometry (warps, registers, banks, read ports, lanes, lane width, tag width)
//   - warp_reg_t: one full warp register (THREAD_NUM lanes of DATA_WIDTH bits)
//   - bank_idx_t / row_idx_t: bank select and in-bank row index for the default geometry
//   - clog2_min1: index width that never collapses to zero bits
package gelato_banked_register_file_pkg;

  localparam int unsigned DefWarpNum   = 4;
  localparam int unsigned DefRegNum    = 32;
  localparam int unsigned DefBankNum   = 4;
  localparam int unsigned DefReadPorts = 3;
  localparam int unsigned DefThreadNum = 32;
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefTagWidth  = 4;

  localparam int unsigned DefBankW = $clog2(DefBankNum);
  localparam int unsigned DefRowW  = $clog2(DefWarpNum * DefRegNum / DefBankNum);

  typedef logic [DefThreadNum*DefDataWidth-1:0] warp_reg_t;
  typedef logic [DefBankW-1:0]                  bank_idx_t;
  typedef logic [DefRowW-1:0]                   row_idx_t;

  function automatic int unsigned clog2_min1(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gelato_rr_arbiter.sv
// Round-robin arbiter, one per register bank.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (pointer returns to 0)
//   en_i          : pointer may advance only while high
//   req_i [N]     : requesting ports
//   gnt_o [N]     : one-hot grant, combinational; lowest index at or after the pointer wins
// After a grant the pointer moves to the granted index + 1 (mod N).
module gelato_rr_arbiter
  import gelato_banked_register_file_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned PtrW = clog2_min1(N);

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            found;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      logic [PtrW-1:0] idx;
      idx = PtrW'((32'(ptr_q) + i) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
        ptr_d      = PtrW'((32'(idx) + 1) % N);
      end
    end
    if (!en_i) begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/gelato_banked_register_file.sv
// Multi-bank, multi-port warp register file between issue and the operand collectors.
// Each bank does one access per cycle; the single masked write always wins its bank, and
// same-bank reads are arbitrated round-robin. Read data returns one cycle after the grant.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   rdy                  : global enable; low freezes storage, pointers and grants
//   rd_valid/rd_ready    : per-port read handshake (ready is the combinational grant)
//   rd_warp/rd_reg/rd_tag: per-port read address and opaque tag
//   rsp_valid/data/tag   : per-port registered response
//   wr_valid/wr_ready    : write handshake (wr_ready = rdy)
//   wr_warp/wr_reg       : write address
//   wr_mask/wr_data      : per-lane write enable and data
// Optional: define GELATO_REGFILE_FORWARD_EN to let a read that exactly matches the
// concurrent write be granted in the same cycle and return the merged (post-write) value.
// Storage is not reset.
module gelato_banked_register_file
  import gelato_banked_register_file_pkg::*;
#(
  parameter int unsigned WARP_NUM   = DefWarpNum,
  parameter int unsigned REG_NUM    = DefRegNum,
  parameter int unsigned BANK_NUM   = DefBankNum,
  parameter int unsigned READ_PORTS = DefReadPorts,
  parameter int unsigned THREAD_NUM = DefThreadNum,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned TAG_WIDTH  = DefTagWidth
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          rdy,
  input  logic [READ_PORTS-1:0]                         rd_valid,
  output logic [READ_PORTS-1:0]                         rd_ready,
  input  logic [READ_PORTS*$clog2(WARP_NUM)-1:0]        rd_warp,
  input  logic [READ_PORTS*$clog2(REG_NUM)-1:0]         rd_reg,
  input  logic [READ_PORTS*TAG_WIDTH-1:0]               rd_tag,
  output logic [READ_PORTS-1:0]                         rsp_valid,
  output logic [READ_PORTS*THREAD_NUM*DATA_WIDTH-1:0]   rsp_data,
  output logic [READ_PORTS*TAG_WIDTH-1:0]               rsp_tag,
  input  logic                                          wr_valid,
  output logic                                          wr_ready,
  input  logic [$clog2(WARP_NUM)-1:0]                   wr_warp,
  input  logic [$clog2(REG_NUM)-1:0]                    wr_reg,
  input  logic [THREAD_NUM-1:0]                         wr_mask,
  input  logic [THREAD_NUM*DATA_WIDTH-1:0]              wr_data
);

  localparam int unsigned WarpW       = $clog2(WARP_NUM);
  localparam int unsigned RegW        = $clog2(REG_NUM);
  localparam int unsigned BankW       = clog2_min1(BANK_NUM);
  localparam int unsigned RegsPerBank = REG_NUM / BANK_NUM;
  localparam int unsigned Rows        = WARP_NUM * RegsPerBank;
  localparam int unsigned RowW        = clog2_min1(Rows);
  localparam int unsigned LaneW       = THREAD_NUM * DATA_WIDTH;

  logic [LaneW-1:0] mem_q [BANK_NUM][Rows];

  logic             wr_fire;
  logic [BankW-1:0] wr_bank;
  logic [RowW-1:0]  wr_row;
  logic [LaneW-1:0] wr_old;
  logic [LaneW-1:0] wr_merged;

  logic [WarpW-1:0]      rd_warp_p [READ_PORTS];
  logic [RegW-1:0]       rd_reg_p  [READ_PORTS];
  logic [BankW-1:0]      rd_bank   [READ_PORTS];
  logic [RowW-1:0]       rd_row    [READ_PORTS];
  logic [READ_PORTS-1:0] fwd_hit;
  logic [READ_PORTS-1:0] bank_req  [BANK_NUM];
  logic [READ_PORTS-1:0] bank_gnt  [BANK_NUM];

  logic [READ_PORTS-1:0]           rsp_valid_q, rsp_valid_d;
  logic [READ_PORTS*LaneW-1:0]     rsp_data_q,  rsp_data_d;
  logic [READ_PORTS*TAG_WIDTH-1:0] rsp_tag_q,   rsp_tag_d;

  // Address decode, write merge and per-bank request vectors.
  always_comb begin
    wr_fire   = rdy & wr_valid;
    wr_bank   = BankW'(32'(wr_reg) % BANK_NUM);
    wr_row    = RowW'(32'(wr_warp) * RegsPerBank + 32'(wr_reg) / BANK_NUM);
    wr_old    = mem_q[wr_bank][wr_row];
    wr_merged = wr_old;
    for (int l = 0; l < THREAD_NUM; l++) begin
      if (wr_mask[l]) begin
        wr_merged[l*DATA_WIDTH +: DATA_WIDTH] = wr_data[l*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    rd_warp_p = '{default: '0};
    rd_reg_p  = '{default: '0};
    rd_bank   = '{default: '0};
    rd_row    = '{default: '0};
    fwd_hit   = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      rd_warp_p[p] = rd_warp[p*WarpW +: WarpW];
      rd_reg_p[p]  = rd_reg[p*RegW +: RegW];
      rd_bank[p]   = BankW'(32'(rd_reg_p[p]) % BANK_NUM);
      rd_row[p]    = RowW'(32'(rd_warp_p[p]) * RegsPerBank + 32'(rd_reg_p[p]) / BANK_NUM);
`ifdef GELATO_REGFILE_FORWARD_EN
      fwd_hit[p]   = wr_fire && rd_valid[p] && (rd_warp_p[p] == wr_warp) &&
                     (rd_reg_p[p] == wr_reg);
`else
      fwd_hit[p]   = 1'b0;
`endif
    end

    // A bank being written only admits reads that hit the written row exactly (forwarding).
    bank_req = '{default: '0};
    for (int b = 0; b < BANK_NUM; b++) begin
      for (int p = 0; p < READ_PORTS; p++) begin
        bank_req[b][p] = rdy && rd_valid[p] && (rd_bank[p] == BankW'(b)) &&
                         (!(wr_fire && (wr_bank == BankW'(b))) || fwd_hit[p]);
      end
    end
  end

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank_arb
    gelato_rr_arbiter #(
      .N(READ_PORTS)
    ) u_arb (
      .clk_i (clk),
      .rst_ni(rst_n),
      .en_i  (rdy),
      .req_i (bank_req[b]),
      .gnt_o (bank_gnt[b])
    );
  end

  // Grants and next response state. Reads see storage before this cycle's write; a forwarded
  // read takes the merged word instead.
  always_comb begin
    rd_ready = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      rd_ready = rd_ready | bank_gnt[b];
    end
    rsp_valid_d = rd_ready;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    for (int p = 0; p < READ_PORTS; p++) begin
      if (rd_ready[p]) begin
        rsp_data_d[p*LaneW +: LaneW] = fwd_hit[p] ? wr_merged : mem_q[rd_bank[p]][rd_row[p]];
        rsp_tag_d[p*TAG_WIDTH +: TAG_WIDTH] = rd_tag[p*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  assign wr_ready  = rdy;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_bank][wr_row] <= wr_merged;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && rdy) begin
      if (wr_valid) begin
        assert ((32'(wr_warp) < WARP_NUM) && (32'(wr_reg) < REG_NUM));
      end
      for (int p = 0; p < READ_PORTS; p++) begin
        if (rd_valid[p]) begin
          assert ((32'(rd_warp_p[p]) < WARP_NUM) && (32'(rd_reg_p[p]) < REG_NUM));
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_gelato_banked_register_file.sv
module tb_gelato_banked_register_file;
  import gelato_banked_register_file_pkg::*;

  localparam int LW = 1024;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           rdy;
  logic [2:0]     rd_valid;
  logic [2:0]     rd_ready;
  logic [5:0]     rd_warp;
  logic [14:0]    rd_reg;
  logic [11:0]    rd_tag;
  logic [2:0]     rsp_valid;
  logic [3*LW-1:0] rsp_data;
  logic [11:0]    rsp_tag;
  logic           wr_valid;
  logic           wr_ready;
  logic [1:0]     wr_warp;
  logic [4:0]     wr_reg;
  logic [31:0]    wr_mask;
  warp_reg_t      wr_data;

  int tests = 0;
  int fails = 0;

  gelato_banked_register_file dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rdy      (rdy),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_warp  (rd_warp),
    .rd_reg   (rd_reg),
    .rd_tag   (rd_tag),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_tag  (rsp_tag),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_warp  (wr_warp),
    .wr_reg   (wr_reg),
    .wr_mask  (wr_mask),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic warp_reg_t fill(input logic [31:0] v);
    return {32{v}};
  endfunction

  function automatic warp_reg_t lane_idx();
    warp_reg_t r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = 32'(i);
    return r;
  endfunction

  function automatic int diff_lane(input warp_reg_t a, input warp_reg_t b);
    for (int i = 0; i < 32; i++) if (a[i*32 +: 32] !== b[i*32 +: 32]) return i;
    return 0;
  endfunction

  task automatic set_rd(input int p, input int w, input int r, input int t);
    rd_valid[p]       = 1'b1;
    rd_warp[p*2 +: 2] = 2'(w);
    rd_reg[p*5 +: 5]  = 5'(r);
    rd_tag[p*4 +: 4]  = 4'(t);
  endtask

  task automatic do_write(input int w, input int r, input logic [31:0] m, input warp_reg_t d);
    wr_valid = 1'b1;
    wr_warp  = 2'(w);
    wr_reg   = 5'(r);
    wr_mask  = m;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    warp_reg_t g;
    rst_n = 1'b0; rdy = 1'b0; rd_valid = '0; rd_warp = '0; rd_reg = '0; rd_tag = '0;
    wr_valid = 1'b0; wr_warp = '0; wr_reg = '0; wr_mask = '0; wr_data = '0;
    tick(); tick();
    tests++;
    if (rsp_valid !== 3'b000) begin
      fails++; $display("FAIL reset_valid: got %b expected 000", rsp_valid);
    end
    tests++;
    if (rsp_tag !== 12'h000) begin
      fails++; $display("FAIL reset_tag: got %h expected 000", rsp_tag);
    end
    for (int p = 0; p < 3; p++) begin
      g = rsp_data[p*LW +: LW];
      tests++;
      if (g !== '0) begin
        fails++;
        $display("FAIL reset_data p%0d lane %0d: got %h expected 0", p, diff_lane(g, '0),
                 g[diff_lane(g, '0)*32 +: 32]);
      end
    end
    rst_n = 1'b1; rdy = 1'b1;
    tick();
  endtask

  // Bank 1 pointer is still 0 here: grants must come out 0, 1, 2 and wrap back to 0.
  task automatic test_rr();
    warp_reg_t g, e;
    do_write(2, 1, 32'hFFFF_FFFF, fill(32'h2000_0001));
    do_write(2, 5, 32'hFFFF_FFFF, fill(32'h2000_0005));
    do_write(2, 9, 32'hFFFF_FFFF, fill(32'h2000_0009));
    set_rd(0, 2, 1, 1); set_rd(1, 2, 5, 2); set_rd(2, 2, 9, 4);
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (rd_ready !== 3'(1 << k)) begin
        fails++; $display("FAIL rr_ready step %0d: got %b expected %b", k, rd_ready, 3'(1 << k));
      end
      tick();
      rd_valid[k] = 1'b0;
      tests++;
      if (rsp_valid !== 3'(1 << k)) begin
        fails++; $display("FAIL rr_valid step %0d: got %b expected %b", k, rsp_valid, 3'(1 << k));
      end
      tests++;
      if (rsp_tag[k*4 +: 4] !== ((k == 2) ? 4'd4 : 4'(k + 1))) begin
        fails++; $display("FAIL rr_tag step %0d: got %0d", k, rsp_tag[k*4 +: 4]);
      end
      g = rsp_data[k*LW +: LW];
      e = fill(32'h2000_0001 + 32'(4 * k));
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL rr_data step %0d lane %0d: got %h expected %h", k, diff_lane(g, e),
                 g[diff_lane(g, e)*32 +: 32], e[diff_lane(g, e)*32 +: 32]);
      end
    end
    set_rd(0, 2, 1, 1); set_rd(1, 2, 5, 2); set_rd(2, 2, 9, 4);
    #1;
    tests++;
    if (rd_ready !== 3'b001) begin
      fails++; $display("FAIL rr_second_round: got %b expected 001", rd_ready);
    end
    tick();
    rd_valid = '0;
    tick();
  endtask

  task automatic test_write_read();
    warp_reg_t g;
    wr_valid = 1'b1; wr_warp = 2'd1; wr_reg = 5'd5; wr_mask = 32'hFFFF_FFFF; wr_data = lane_idx();
    #1;
    tests++;
    if (wr_ready !== 1'b1) begin
      fails++; $display("FAIL wr_ready: got %b expected 1", wr_ready);
    end
    tick();
    wr_valid = 1'b0;
    set_rd(0, 1, 5, 3);
    #1;
    tests++;
    if (rd_ready !== 3'b001) begin
      fails++; $display("FAIL wrrd_ready: got %b expected 001", rd_ready);
    end
    tick();
    rd_valid = '0;
    tests++;
    if (rsp_valid !== 3'b001) begin
      fails++; $display("FAIL wrrd_valid: got %b expected 001", rsp_valid);
    end
    g = rsp_data[0 +: LW];
    tests++;
    if (g !== lane_idx()) begin
      fails++;
      $display("FAIL wrrd_data lane %0d: got %h expected %0d", diff_lane(g, lane_idx()),
               g[diff_lane(g, lane_idx())*32 +: 32], diff_lane(g, lane_idx()));
    end
    tests++;
    if (rsp_tag[3:0] !== 4'd3) begin
      fails++; $display("FAIL wrrd_tag: got %0d expected 3", rsp_tag[3:0]);
    end
    tick();
    tests++;
    if (rsp_valid !== 3'b000) begin
      fails++; $display("FAIL wrrd_valid_drop: got %b expected 000", rsp_valid);
    end
    g = rsp_data[0 +: LW];
    tests++;
    if (g !== lane_idx() || rsp_tag[3:0] !== 4'd3) begin
      fails++; $display("FAIL wrrd_hold: tag got %0d expected 3, lane0 got %h", rsp_tag[3:0], g[31:0]);
    end
  endtask

  task automatic test_masked();
    warp_reg_t g, e;
    do_write(0, 2, 32'hFFFF_FFFF, fill(32'h5555_5555));
    do_write(0, 2, 32'h0000_FFFF, fill(32'hAAAA_AAAA));
    set_rd(1, 0, 2, 7);
    tick();
    rd_valid = '0;
    e = {{16{32'h5555_5555}}, {16{32'hAAAA_AAAA}}};
    g = rsp_data[LW +: LW];
    tests++;
    if (rsp_valid !== 3'b010 || rsp_tag[7:4] !== 4'd7) begin
      fails++; $display("FAIL mask_rsp: valid %b tag %0d expected 010 tag 7", rsp_valid, rsp_tag[7:4]);
    end
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL mask_data lane %0d: got %h expected %h", diff_lane(g, e),
               g[diff_lane(g, e)*32 +: 32], e[diff_lane(g, e)*32 +: 32]);
    end
  endtask

  task automatic test_parallel();
    warp_reg_t g, e;
    do_write(3, 0, 32'hFFFF_FFFF, fill(32'h3000_0000));
    do_write(3, 1, 32'hFFFF_FFFF, fill(32'h3000_0001));
    do_write(3, 2, 32'hFFFF_FFFF, fill(32'h3000_0002));
    set_rd(0, 3, 0, 8); set_rd(1, 3, 1, 9); set_rd(2, 3, 2, 10);
    #1;
    tests++;
    if (rd_ready !== 3'b111) begin
      fails++; $display("FAIL par_ready: got %b expected 111", rd_ready);
    end
    tick();
    rd_valid = '0;
    tests++;
    if (rsp_valid !== 3'b111) begin
      fails++; $display("FAIL par_valid: got %b expected 111", rsp_valid);
    end
    for (int p = 0; p < 3; p++) begin
      g = rsp_data[p*LW +: LW];
      e = fill(32'h3000_0000 + 32'(p));
      tests++;
      if (g !== e || rsp_tag[p*4 +: 4] !== 4'(8 + p)) begin
        fails++;
        $display("FAIL par_rsp p%0d: tag %0d lane0 %h expected tag %0d lane0 %h", p,
                 rsp_tag[p*4 +: 4], g[31:0], 8 + p, e[31:0]);
      end
    end
  endtask

  task automatic test_conflict();
    warp_reg_t g, e;
    do_write(1, 8, 32'hFFFF_FFFF, fill(32'h1818_1818));
    wr_valid = 1'b1; wr_warp = 2'd1; wr_reg = 5'd4; wr_mask = 32'hFFFF_FFFF;
    wr_data = fill(32'h1414_1414);
    set_rd(0, 1, 8, 5);
    #1;
    tests++;
    if (rd_ready !== 3'b000) begin
      fails++; $display("FAIL conf_stall: got %b expected 000", rd_ready);
    end
    tick();
    wr_valid = 1'b0;
    tests++;
    if (rsp_valid !== 3'b000) begin
      fails++; $display("FAIL conf_no_rsp: got %b expected 000", rsp_valid);
    end
    #1;
    tests++;
    if (rd_ready !== 3'b001) begin
      fails++; $display("FAIL conf_retry: got %b expected 001", rd_ready);
    end
    tick();
    rd_valid = '0;
    g = rsp_data[0 +: LW];
    tests++;
    if (rsp_valid !== 3'b001 || rsp_tag[3:0] !== 4'd5 || g !== fill(32'h1818_1818)) begin
      fails++; $display("FAIL conf_rsp: valid %b tag %0d lane0 %h expected 001 5 18181818",
                        rsp_valid, rsp_tag[3:0], g[31:0]);
    end
    set_rd(2, 1, 4, 6);
    tick();
    rd_valid = '0;
    g = rsp_data[2*LW +: LW];
    tests++;
    if (g !== fill(32'h1414_1414)) begin
      fails++; $display("FAIL conf_write_landed: lane0 %h expected 14141414", g[31:0]);
    end
`ifdef GELATO_REGFILE_FORWARD_EN
    wr_valid = 1'b1; wr_warp = 2'd1; wr_reg = 5'd4; wr_mask = 32'h0000_00FF;
    wr_data = fill(32'hF4F4_F4F4);
    set_rd(2, 1, 4, 11); set_rd(1, 1, 8, 12);
    #1;
    tests++;
    if (rd_ready !== 3'b100) begin
      fails++; $display("FAIL fwd_ready: got %b expected 100", rd_ready);
    end
    tick();
    wr_valid = 1'b0;
    rd_valid[2] = 1'b0;
    e = {{24{32'h1414_1414}}, {8{32'hF4F4_F4F4}}};
    g = rsp_data[2*LW +: LW];
    tests++;
    if (rsp_valid !== 3'b100 || g !== e) begin
      fails++; $display("FAIL fwd_data: valid %b lane %0d got %h expected %h", rsp_valid,
                        diff_lane(g, e), g[diff_lane(g, e)*32 +: 32], e[diff_lane(g, e)*32 +: 32]);
    end
    #1;
    tests++;
    if (rd_ready !== 3'b010) begin
      fails++; $display("FAIL fwd_other_row_stall: got %b expected 010", rd_ready);
    end
    tick();
    rd_valid = '0;
`endif
  endtask

  task automatic test_rdy();
    warp_reg_t g;
    do_write(3, 3, 32'hFFFF_FFFF, fill(32'h3333_3333));
    set_rd(0, 3, 0, 1);
    tick();
    tests++;
    if (rsp_valid !== 3'b001) begin
      fails++; $display("FAIL rdy_pre_valid: got %b expected 001", rsp_valid);
    end
    rdy = 1'b0;
    set_rd(1, 3, 3, 2);
    wr_valid = 1'b1; wr_warp = 2'd3; wr_reg = 5'd3; wr_mask = 32'hFFFF_FFFF;
    wr_data = fill(32'hDEAD_BEEF);
    for (int k = 0; k < 2; k++) begin
      #1;
      tests++;
      if (rd_ready !== 3'b000 || wr_ready !== 1'b0) begin
        fails++; $display("FAIL rdy_frozen %0d: rd_ready %b wr_ready %b expected 000 0", k,
                          rd_ready, wr_ready);
      end
      tick();
      g = rsp_data[0 +: LW];
      tests++;
      if (rsp_valid !== 3'b000 || g !== fill(32'h3000_0000)) begin
        fails++; $display("FAIL rdy_rsp %0d: valid %b lane0 %h expected 000 30000000", k,
                          rsp_valid, g[31:0]);
      end
    end
    rdy = 1'b1;
    wr_valid = 1'b0;
    rd_valid = '0;
    set_rd(1, 3, 3, 2);
    tick();
    rd_valid = '0;
    g = rsp_data[LW +: LW];
    tests++;
    if (rsp_valid !== 3'b010 || g !== fill(32'h3333_3333)) begin
      fails++; $display("FAIL rdy_no_write: valid %b lane0 %h expected 010 33333333",
                        rsp_valid, g[31:0]);
    end
  endtask

  task automatic test_reset_mid();
    warp_reg_t g;
    set_rd(0, 3, 1, 13);
    tick();
    tests++;
    if (rsp_valid !== 3'b001 || rsp_tag[3:0] !== 4'd13) begin
      fails++; $display("FAIL rstm_pre: valid %b tag %0d expected 001 13", rsp_valid, rsp_tag[3:0]);
    end
    rst_n = 1'b0;
    #1;
    g = rsp_data[0 +: LW];
    tests++;
    if (rsp_valid !== 3'b000 || rsp_tag !== 12'h000 || g !== '0) begin
      fails++; $display("FAIL rstm_async: valid %b tag %h lane0 %h expected 000 000 0",
                        rsp_valid, rsp_tag, g[31:0]);
    end
    tick();
    rst_n = 1'b1;
    rd_valid = '0;
    tick();
    tests++;
    if (rsp_valid !== 3'b000) begin
      fails++; $display("FAIL rstm_no_stale: got %b expected 000", rsp_valid);
    end
    tick();
    tests++;
    if (rsp_valid !== 3'b000) begin
      fails++; $display("FAIL rstm_quiet: got %b expected 000", rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_rr();
    test_write_read();
    test_masked();
    test_parallel();
    test_conflict();
    test_rdy();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
